// File: rtl/vga_varredura.sv
// VGA 640x480@60 raster generator for a 50 MHz clock: two clks per pixel,
// map cell address/read strobe on the read phase, registered DAC/sync output on the next.
module vga_varredura #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CELL_SHIFT = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       vga_read,
    output logic [9:0] mapa_x_read,
    output logic [9:0] mapa_y_read,
    input  logic [1:0] mapa_R,
    input  logic [1:0] mapa_G,
    input  logic [1:0] mapa_B,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ALAST  = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SSTART = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SEND   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ALAST  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_SSTART = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SEND   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic          r_ph;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_act_d;
    logic          r_hs_d;
    logic          r_vs_d;

    logic          w_active;
    logic          w_hs;
    logic          w_vs;
    logic          w_h_last;
    logic          w_v_last;

    assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_hs     = !((r_h >= H_SSTART) && (r_h < H_SEND));
    assign w_vs     = !((r_v >= V_SSTART) && (r_v < V_SEND));
    assign w_h_last = (r_h == H_LAST);
    assign w_v_last = (r_v == V_LAST);

    // Gate with reset so a read never leaks out while the counters are being cleared.
    assign vga_read    = r_ph && w_active && !reset;
    assign mapa_x_read = w_active ? 10'(r_h >> CELL_SHIFT) : 10'd0;
    assign mapa_y_read = w_active ? 10'(r_v >> CELL_SHIFT) : 10'd0;
    assign VGA_SYNC_N  = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ph        <= 1'b0;
            r_h         <= '0;
            r_v         <= '0;
            r_act_d     <= 1'b0;
            r_hs_d      <= 1'b1;
            r_vs_d      <= 1'b1;
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_CLK     <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            r_ph       <= ~r_ph;
            VGA_CLK    <= r_ph;
            frame_tick <= r_ph && (r_h == H_ALAST) && (r_v == V_ALAST);
            if (r_ph) begin
                // Read phase: advance the raster and stage this pixel's timing.
                r_act_d <= w_active;
                r_hs_d  <= w_hs;
                r_vs_d  <= w_vs;
                if (w_h_last) begin
                    r_h <= '0;
                    r_v <= w_v_last ? '0 : r_v + VW'(1);
                end else begin
                    r_h <= r_h + HW'(1);
                end
            end else begin
                // Output phase: map reply is valid now; blanking forces black so
                // undriven map data never reaches the DAC.
                VGA_R       <= r_act_d ? {4{mapa_R}} : 8'h00;
                VGA_G       <= r_act_d ? {4{mapa_G}} : 8'h00;
                VGA_B       <= r_act_d ? {4{mapa_B}} : 8'h00;
                VGA_HS      <= r_hs_d;
                VGA_VS      <= r_vs_d;
                VGA_BLANK_N <= r_act_d;
            end
        end
    end

endmodule

// File: tb/tb_vga_varredura.sv
// Bench for vga_varredura: full-size instance for line-level checks, a shrunken
// instance with a pixel scoreboard for frame-level timing and colour pipeline.
module tb_vga_varredura;

    // Shrunken geometry for the frame-level instance.
    localparam int BHA = 32, BHFP = 4, BHS = 8, BHBP = 4;
    localparam int BVA = 16, BVFP = 2, BVS = 2, BVBP = 3;
    localparam int BCS = 2;
    localparam int BHT = BHA + BHFP + BHS + BHBP;
    localparam int BVT = BVA + BVFP + BVS + BVBP;

    typedef struct {
        int ph; int h; int v;
        bit rd; int x; int y;
    } vec_t;

    typedef struct {
        bit act; bit hs; bit vs;
        logic [7:0] r; logic [7:0] g; logic [7:0] b;
    } pix_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_a, rst_b;
    logic [1:0] ra, ga, ba, rb, gb, bb;
    logic       rd_a, rd_b;
    logic [9:0] xa, ya, xb, yb;
    logic [7:0] oRa, oGa, oBa, oRb, oGb, oBb;
    logic       hs_a, vs_a, bl_a, sn_a, vc_a, ft_a;
    logic       hs_b, vs_b, bl_b, sn_b, vc_b, ft_b;

    vga_varredura dut_a (
        .clk(clk), .reset(rst_a), .vga_read(rd_a),
        .mapa_x_read(xa), .mapa_y_read(ya),
        .mapa_R(ra), .mapa_G(ga), .mapa_B(ba),
        .VGA_R(oRa), .VGA_G(oGa), .VGA_B(oBa),
        .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bl_a),
        .VGA_SYNC_N(sn_a), .VGA_CLK(vc_a), .frame_tick(ft_a)
    );

    vga_varredura #(
        .H_ACTIVE(BHA), .H_FP(BHFP), .H_SYNC(BHS), .H_BP(BHBP),
        .V_ACTIVE(BVA), .V_FP(BVFP), .V_SYNC(BVS), .V_BP(BVBP),
        .CELL_SHIFT(BCS)
    ) dut_b (
        .clk(clk), .reset(rst_b), .vga_read(rd_b),
        .mapa_x_read(xb), .mapa_y_read(yb),
        .mapa_R(rb), .mapa_G(gb), .mapa_B(bb),
        .VGA_R(oRb), .VGA_G(oGb), .VGA_B(oBb),
        .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bl_b),
        .VGA_SYNC_N(sn_b), .VGA_CLK(vc_b), .frame_tick(ft_b)
    );

    int nvec = 0;
    int nerr = 0;
    int ka   = 0;
    bit g_on = 1'b0;
    int g_err = 0;
    bit a_done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            if (nerr <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clk on the full-size instance, with the continuous colour-vs-blank watch.
    task automatic tick_a();
        @(negedge clk);
        ka++;
        if (g_on) begin
            if (oGa !== (bl_a ? 8'hFF : 8'h00)) g_err++;
            if (sn_a !== 1'b0) g_err++;
        end
    endtask

    task automatic step_to(input int ph, input int h, input int v);
        int target;
        target = 2 * (v * 800 + h) + ph;
        while (ka < target) tick_a();
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_R"}, oRa, 0);
        chk({tag, "_G"}, oGa, 0);
        chk({tag, "_B"}, oBa, 0);
        chk({tag, "_HS"}, hs_a, 1);
        chk({tag, "_VS"}, vs_a, 1);
        chk({tag, "_BLANK"}, bl_a, 0);
        chk({tag, "_VCLK"}, vc_a, 0);
        chk({tag, "_TICK"}, ft_a, 0);
        chk({tag, "_READ"}, rd_a, 0);
        chk({tag, "_SYNCN"}, sn_a, 0);
    endtask

    initial begin
        vec_t vt[10];
        vt[0] = '{1, 15, 0, 1'b1, 0, 0};
        vt[1] = '{1, 16, 0, 1'b1, 1, 0};
        vt[2] = '{0, 17, 0, 1'b0, 1, 0};
        vt[3] = '{1, 639, 0, 1'b1, 39, 0};
        vt[4] = '{1, 640, 0, 1'b0, 0, 0};
        vt[5] = '{1, 799, 0, 1'b0, 0, 0};
        vt[6] = '{1, 0, 1, 1'b1, 0, 0};
        vt[7] = '{1, 100, 16, 1'b1, 6, 1};
        vt[8] = '{1, 5, 31, 1'b1, 0, 1};
        vt[9] = '{1, 200, 32, 1'b1, 12, 2};

        rst_a = 1'b1; rst_b = 1'b1;
        ra = 2'b00; ga = 2'b00; ba = 2'b00;
        rb = 2'b00; gb = 2'b00; bb = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        fork
            begin : seq_a
                int k0, fall, fall2, low, vs_low;
                chk_reset_a("rst0");
                step_to(1, 0, 0);
                chk("first_read", rd_a, 1);
                chk("first_x", xa, 0);
                chk("first_y", ya, 0);
                ra = 2'b11; ga = 2'b01; ba = 2'b10;
                tick_a();
                chk("vclk_hi", vc_a, 1);
                tick_a();
                chk("pix0_R", oRa, 8'hFF);
                chk("pix0_G", oGa, 8'h55);
                chk("pix0_B", oBa, 8'hAA);
                chk("pix0_BLANK", bl_a, 1);
                chk("pix0_HS", hs_a, 1);
                ra = 2'b00; ga = 2'b11; ba = 2'b00;

                foreach (vt[i]) begin
                    step_to(vt[i].ph, vt[i].h, vt[i].v);
                    if (i == 1) g_on = 1'b1;
                    chk($sformatf("vec%0d_read", i), rd_a, vt[i].rd);
                    chk($sformatf("vec%0d_x", i), xa, vt[i].x);
                    chk($sformatf("vec%0d_y", i), ya, vt[i].y);
                end

                // Line timing measured from the h=0 read cycle of line 33.
                step_to(1, 0, 33);
                k0 = ka; fall = -1;
                for (int n = 0; n < 2000 && fall < 0; n++) begin
                    tick_a();
                    if (hs_a == 1'b0) fall = ka;
                end
                chk("hs_fall_offset", fall - k0, 2 * 656 + 2);
                low = 0;
                while (hs_a == 1'b0 && low < 400) begin tick_a(); low++; end
                chk("hs_low_width", low, 192);
                fall2 = -1;
                for (int n = 0; n < 2000 && fall2 < 0; n++) begin
                    tick_a();
                    if (hs_a == 1'b0) fall2 = ka;
                end
                chk("hs_period", fall2 - fall, 1600);

                // Mid-line reset during a read cycle.
                step_to(1, 300, 35);
                rst_a = 1'b1;
                #1;
                chk("rst_read_gated", rd_a, 0);
                @(negedge clk);
                chk_reset_a("rst_mid");
                rst_a = 1'b0;
                ka = 0;
                step_to(1, 0, 0);
                chk("restart_read", rd_a, 1);
                chk("restart_x", xa, 0);
                chk("restart_y", ya, 0);
                fall = -1; vs_low = 0;
                for (int n = 0; n < 2000 && fall < 0; n++) begin
                    tick_a();
                    if (vs_a == 1'b0) vs_low++;
                    if (hs_a == 1'b0) fall = ka;
                end
                chk("restart_hs_first_fall", fall, 1 + 2 * 656 + 2);
                chk("restart_vs_quiet", vs_low, 0);
                chk("g_blank_zero", g_err, 0);
                a_done = 1'b1;
            end

            begin : sb_b
                int mph, mh, mv, mclk, mtick, bk, last_tick, nticks;
                bit act;
                logic [1:0] cr, cg, cb;
                pix_t pend[$];
                pix_t outq[$];
                pix_t p;
                mph = 0; mh = 0; mv = 0; mclk = 0; mtick = 0;
                bk = 0; last_tick = -1; nticks = 0;
                while (!a_done) begin
                    act = (mh < BHA) && (mv < BVA);
                    chk("b_read", rd_b, (mph == 1 && act) ? 1 : 0);
                    chk("b_x", xb, act ? (mh >> BCS) : 0);
                    chk("b_y", yb, act ? (mv >> BCS) : 0);
                    chk("b_tick", ft_b, mtick);
                    chk("b_vclk", vc_b, mclk);
                    chk("b_syncn", sn_b, 0);
                    if (ft_b) begin
                        if (last_tick >= 0) chk("b_frame_period", bk - last_tick, 2 * BHT * BVT);
                        last_tick = bk;
                        nticks++;
                    end
                    if (mph == 1) begin
                        if (outq.size() > 0) begin
                            p = outq.pop_front();
                            chk("b_R", oRb, p.r);
                            chk("b_G", oGb, p.g);
                            chk("b_B", oBb, p.b);
                            chk("b_BLANK", bl_b, p.act);
                            chk("b_HS", hs_b, p.hs);
                            chk("b_VS", vs_b, p.vs);
                        end else begin
                            chk("b_rst_R", oRb, 0);
                            chk("b_rst_BLANK", bl_b, 0);
                            chk("b_rst_HS", hs_b, 1);
                            chk("b_rst_VS", vs_b, 1);
                        end
                        p.act = act;
                        p.hs  = !(mh >= BHA + BHFP && mh < BHA + BHFP + BHS);
                        p.vs  = !(mv >= BVA + BVFP && mv < BVA + BVFP + BVS);
                        p.r = 8'h00; p.g = 8'h00; p.b = 8'h00;
                        pend.push_back(p);
                    end else if (pend.size() > 0) begin
                        // Map reply for the pending read; random even in blanking.
                        p  = pend.pop_front();
                        cr = 2'($urandom_range(0, 3));
                        cg = 2'($urandom_range(0, 3));
                        cb = 2'($urandom_range(0, 3));
                        rb = cr; gb = cg; bb = cb;
                        p.r = p.act ? {4{cr}} : 8'h00;
                        p.g = p.act ? {4{cg}} : 8'h00;
                        p.b = p.act ? {4{cb}} : 8'h00;
                        outq.push_back(p);
                    end
                    mclk  = mph;
                    mtick = (mph == 1 && mh == BHA - 1 && mv == BVA - 1) ? 1 : 0;
                    if (mph == 1) begin
                        if (mh == BHT - 1) begin
                            mh = 0;
                            mv = (mv == BVT - 1) ? 0 : mv + 1;
                        end else begin
                            mh = mh + 1;
                        end
                    end
                    mph = 1 - mph;
                    @(negedge clk);
                    bk++;
                end
                chk("b_ticks_seen_min", (nticks >= 3) ? 1 : 0, 1);
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
